alu_exec_unit: RTL and testbench

Single-ALU execute unit on the receiving end of the issue queue's `isqIssueIf` link. It evaluates the issued ALU command on `op1`/`op2` and stores `{phys_rd, result}` in a small in-order result FIFO. The FIFO drains to the writeback/commit stage over a valid/ready port. Because the issue interface has no ready signal, the unit returns a stall indication to the issue queue and flags any overflow.

---
 rtl/alu_exec_unit_if.sv | 30 +++
 rtl/alu_exec_unit.sv | 109 ++++++++++
 tb/tb_alu_exec_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Shared ALU command encoding and the issue-queue -> execute link.
// Package first so the interface and the execute unit can import it.
package common;
  localparam int PHYS_REGS_ADDR_WIDTH = 6;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_cmd_t;
endpackage

interface isqIssueIf;
  import common::*;
  logic                            valid;
  alu_cmd_t                        alu_cmd;
  logic [31:0]                     op1;
  logic [31:0]                     op2;
  logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;

  modport in  (input  valid, alu_cmd, op1, op2, phys_rd);
  modport out (output valid, alu_cmd, op1, op2, phys_rd);
endinterface

// File: rtl/alu_exec_unit.sv
// Single-ALU execute unit: combinational ALU into an in-order result FIFO
// drained over valid/ready. Optional forward ports under ALU_EXEC_FWD_EN.
module alu_exec_unit
  import common::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_MARGIN = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  isqIssueIf.in                           issue,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd,
  output logic [31:0]                     wb_data,
  output logic                            issue_stall,
  output logic [$clog2(FIFO_DEPTH):0]     occupancy,
`ifdef ALU_EXEC_FWD_EN
  output logic                            fwd_valid,
  output logic [PHYS_REGS_ADDR_WIDTH-1:0] fwd_phys_rd,
  output logic [31:0]                     fwd_data,
`endif
  output logic                            overflow_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] FULL_CNT = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0] STALL_TH = OW'(FIFO_DEPTH - STALL_MARGIN);

  typedef struct packed {
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
    logic [31:0]                     data;
  } wb_entry_t;

  function automatic logic [31:0] alu_eval(alu_cmd_t cmd, logic [31:0] a, logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (cmd)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return $signed(a) >>> sh;
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return '0;
    endcase
  endfunction

  wb_entry_t         mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, head_ptr;
  logic [OW-1:0]     occ;
  logic              full, pop, push, drop;
  wb_entry_t         new_entry;

  assign full      = (occ == FULL_CNT);
  assign wb_valid  = (occ != '0);
  assign pop       = wb_valid && wb_ready;
  assign push      = issue.valid && (!full || pop);
  assign drop      = issue.valid && full && !pop;
  assign new_entry = '{phys_rd: issue.phys_rd,
                       data: alu_eval(issue.alu_cmd, issue.op1, issue.op2)};

  // When empty, show the slot just popped so wb_* hold their last value;
  // a push can never target that slot while the FIFO is empty.
  assign head_ptr    = (occ == '0) ? rd_ptr - 1'b1 : rd_ptr;
  assign wb_phys_rd  = mem[head_ptr].phys_rd;
  assign wb_data     = mem[head_ptr].data;
  assign occupancy   = occ;
  assign issue_stall = (occ >= STALL_TH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
      if (drop) overflow_err <= 1'b1;
    end
  end

`ifdef ALU_EXEC_FWD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid   <= 1'b0;
      fwd_phys_rd <= '0;
      fwd_data    <= '0;
    end else begin
      fwd_valid <= push;
      if (push) begin
        fwd_phys_rd <= new_entry.phys_rd;
        fwd_data    <= new_entry.data;
      end
    end
  end
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (depth 4, margin 1).
module tb_alu_exec_unit;
  import common::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid, wb_ready, issue_stall, overflow_err;
  logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd;
  logic [31:0] wb_data;
  logic [2:0]  occupancy;
`ifdef ALU_EXEC_FWD_EN
  logic        fwd_valid;
  logic [PHYS_REGS_ADDR_WIDTH-1:0] fwd_phys_rd;
  logic [31:0] fwd_data;
`endif
  int n_chk = 0;
  int n_fail = 0;

  isqIssueIf isq();

  alu_exec_unit #(.FIFO_DEPTH(4), .STALL_MARGIN(1)) dut (
    .clk(clk), .rst_n(rst_n), .issue(isq),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_phys_rd(wb_phys_rd), .wb_data(wb_data),
    .issue_stall(issue_stall), .occupancy(occupancy),
`ifdef ALU_EXEC_FWD_EN
    .fwd_valid(fwd_valid), .fwd_phys_rd(fwd_phys_rd), .fwd_data(fwd_data),
`endif
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [PHYS_REGS_ADDR_WIDTH-1:0] rd);
    isq.valid   = 1'b1;
    isq.alu_cmd = alu_cmd_t'(cmd);
    isq.op1     = a;
    isq.op2     = b;
    isq.phys_rd = rd;
  endtask

  task automatic idle();
    isq.valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wb_valid"},  32'(wb_valid), 32'd0);
    chk({tag, ".wb_data"},   wb_data, 32'd0);
    chk({tag, ".wb_rd"},     32'(wb_phys_rd), 32'd0);
    chk({tag, ".occ"},       32'(occupancy), 32'd0);
    chk({tag, ".stall"},     32'(issue_stall), 32'd0);
    chk({tag, ".overflow"},  32'(overflow_err), 32'd0);
`ifdef ALU_EXEC_FWD_EN
    chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'd0);
    chk({tag, ".fwd_data"},  fwd_data, 32'd0);
`endif
  endtask

  // cmd, op1, op2, expected result
  logic [3:0]  v_cmd [11] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'hC};
  logic [31:0] v_a   [11] = '{32'd5, 32'd3, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
                              32'h80000000, 32'hF0F0F0F0, 32'h0F000000, 32'hFFFF0000, 32'd5};
  logic [31:0] v_b   [11] = '{32'd7, 32'd5, 32'd4, 32'd1, 32'd1, 32'h21,
                              32'd31, 32'h0FF00FF0, 32'h000000F0, 32'h12345678, 32'd7};
  logic [31:0] v_exp [11] = '{32'd12, 32'hFFFFFFFE, 32'hF8000000, 32'd1, 32'd0, 32'd2,
                              32'd1, 32'hFF00FF00, 32'h0F0000F0, 32'h12340000, 32'd0};

  logic [31:0] d_data [4] = '{32'd102, 32'd103, 32'd104, 32'd200};
  logic [5:0]  d_rd   [4] = '{6'd11, 6'd12, 6'd13, 6'd21};

  initial begin
    isq.valid = 1'b0; isq.alu_cmd = ALU_ADD; isq.op1 = '0; isq.op2 = '0; isq.phys_rd = '0;
    wb_ready = 1'b1;
    #3;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // single ADD, latency 1, then drained
    @(negedge clk); drive(4'd0, 32'd5, 32'd7, 6'd3);
    @(negedge clk); idle();
    chk("add.valid", 32'(wb_valid), 32'd1);
    chk("add.rd",    32'(wb_phys_rd), 32'd3);
    chk("add.data",  wb_data, 32'd12);
`ifdef ALU_EXEC_FWD_EN
    chk("add.fwd_valid", 32'(fwd_valid), 32'd1);
    chk("add.fwd_data",  fwd_data, 32'd12);
`endif
    @(negedge clk);
    chk("add.occ_after", 32'(occupancy), 32'd0);
    chk("add.valid_after", 32'(wb_valid), 32'd0);
    chk("add.hold_data", wb_data, 32'd12);

    // ALU op table
    for (int i = 0; i < 11; i++) begin
      drive(v_cmd[i], v_a[i], v_b[i], 6'(i + 1));
      @(negedge clk); idle();
      chk($sformatf("alu%0d.valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("alu%0d.data", i), wb_data, v_exp[i]);
      @(negedge clk);
    end

    // fill with consumer stalled
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        chk($sformatf("fill%0d.occ", i), 32'(occupancy), 32'(i));
        chk($sformatf("fill%0d.stall", i), 32'(issue_stall), 32'(i >= 3));
      end
      drive(4'd0, 32'(i + 1), 32'd100, 6'(i + 10));
      @(negedge clk);
    end
    idle();
    chk("full.occ", 32'(occupancy), 32'd4);
    chk("full.stall", 32'(issue_stall), 32'd1);
    chk("full.head", wb_data, 32'd101);

    // push and pop together while full
    wb_ready = 1'b1; drive(4'd0, 32'd200, 32'd0, 6'd21);
    @(negedge clk); idle(); wb_ready = 1'b0;
    chk("pp.occ", 32'(occupancy), 32'd4);
    chk("pp.overflow", 32'(overflow_err), 32'd0);
    chk("pp.head", wb_data, 32'd102);

    // overflow: dropped entry, sticky flag
    drive(4'd0, 32'd999, 32'd0, 6'd30);
    @(negedge clk); idle();
    chk("ovf.flag", 32'(overflow_err), 32'd1);
    chk("ovf.occ", 32'(occupancy), 32'd4);
`ifdef ALU_EXEC_FWD_EN
    chk("ovf.fwd_valid", 32'(fwd_valid), 32'd0);
`endif
    @(negedge clk);
    chk("ovf.sticky", 32'(overflow_err), 32'd1);

    // drain in order
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d.valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("drain%0d.data", i), wb_data, d_data[i]);
      chk($sformatf("drain%0d.rd", i), 32'(wb_phys_rd), 32'(d_rd[i]));
      @(negedge clk);
    end
    chk("drain.occ", 32'(occupancy), 32'd0);
    chk("drain.sticky", 32'(overflow_err), 32'd1);

    // three entries, then async reset mid-cycle
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'd0, 32'(i), 32'd50, 6'(i + 40));
      @(negedge clk);
    end
    idle();
    chk("pre_rst.occ", 32'(occupancy), 32'd3);
    chk("pre_rst.stall", 32'(issue_stall), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk); rst_n = 1'b1; wb_ready = 1'b1;
    @(negedge clk); drive(4'd0, 32'd1, 32'd1, 6'd5);
    @(negedge clk); idle();
    chk("post_rst.valid", 32'(wb_valid), 32'd1);
    chk("post_rst.data", wb_data, 32'd2);
    chk("post_rst.rd", 32'(wb_phys_rd), 32'd5);
    @(negedge clk);
    chk("post_rst.occ", 32'(occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
